// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle add/subtract sequencer: one nibble per cycle through a single
// 4-bit adder, carry chained through a flop, valid/ready on both sides.

module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);
  assign {c4, s} = 5'(a) + 5'(b) + 5'(c0);
endmodule

module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   sub,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic                   busy
);
  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d, ovf_q, ovf_d;

  logic [W-1:0]       a_shift, b_shift;
  logic [3:0]         sum;
  logic               c4;
  logic               last;

  assign a_shift = a_q >> (4 * idx_q);
  assign b_shift = b_q >> (4 * idx_q);
  assign last    = (idx_q == IDX_W'(NIBBLES - 1));

  four_bit_adder u_add (
    .a  (a_shift[3:0]),
    .b  (b_shift[3:0]),
    .c0 (carry_q),
    .s  (sum),
    .c4 (c4)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (last)        state_d = DONE;
      DONE:    if (res_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);
    busy        = (state_q != IDLE);
  end

  // Subtraction is folded into the operands at acceptance: B is stored
  // inverted and the +1 enters as the initial carry.
  always_comb begin
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (state_q == IDLE && start_valid) begin
      a_d      = op_a;
      b_d      = sub ? ~op_b : op_b;
      carry_d  = sub;
      idx_d    = '0;
      result_d = '0;
    end else if (state_q == RUN) begin
      result_d = (result_q & ~(W'(4'hF) << (4 * idx_q))) | (W'(sum) << (4 * idx_q));
      carry_d  = c4;
      idx_d    = idx_q + 1'b1;
      if (last) begin
        cout_d = c4;
        ovf_d  = (a_q[W-1] == b_q[W-1]) && (sum[3] != a_q[W-1]);
      end
    end
  end

  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed checks of nibble_serial_adder_ctrl against an
// arithmetic reference model.

module tb_nibble_serial_adder_ctrl;
  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a, op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic, unsigned compare for carry,
  // signed range test for overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    int unsigned ua = a;
    int unsigned ub = b;
    int          sa = $signed({{(32-W){a[W-1]}}, a});
    int          sb = $signed({{(32-W){b[W-1]}}, b});
    int          sv;
    logic [W-1:0] r;
    logic        c, v;
    if (s) begin
      r  = W'(ua - ub);
      c  = (ua >= ub);
      sv = sa - sb;
    end else begin
      r  = W'(ua + ub);
      c  = ((ua + ub) > ((1 << W) - 1));
      sv = sa + sb;
    end
    v = (sv > ((1 << (W-1)) - 1)) || (sv < -(1 << (W-1)));
    return {v, c, r};
  endfunction

  task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             input string tag);
    logic [W+1:0] exp;
    int lat = 0;
    exp = model(a, b, s);
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      op_a = W'($urandom);
      op_b = W'($urandom);
      sub  = 1'($urandom);
      if (res_valid || lat > 20) break;
      chk({tag, " busy"}, busy, 1);
    end
    chk({tag, " latency"}, lat, NIB);
    chk({tag, " result"}, result, exp[W-1:0]);
    chk({tag, " carry"}, carry_out, exp[W]);
    chk({tag, " ovf"}, overflow, exp[W+1]);
  endtask

  task automatic release_result(input logic [W-1:0] held, input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk({tag, " valid drop"}, res_valid, 0);
    chk({tag, " idle ready"}, start_ready, 1);
    chk({tag, " held"}, result, held);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input string tag);
    logic [W+1:0] exp;
    exp = model(a, b, s);
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub  = s;
    chk({tag, " start_ready"}, start_ready, 1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    wait_result(a, b, s, tag);
    release_result(exp[W-1:0], tag);
  endtask

  initial begin
    logic [W+1:0] exp;
    logic [W-1:0] ha;
    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    sub  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst result", result, 0);
    chk("rst carry", carry_out, 0);
    chk("rst ovf", overflow, 0);
    chk("rst valid", res_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst ready", start_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op(16'h1234, 16'h0FFF, 1'b0, "add1");
    do_op(16'hFFFF, 16'h0001, 1'b0, "addwrap");
    do_op(16'h7FFF, 16'h0001, 1'b0, "addovf");
    do_op(16'h0005, 16'h0007, 1'b1, "subneg");
    do_op(16'h8000, 16'h0001, 1'b1, "subovf");

    // Backpressure with a new command held pending.
    start_valid = 1'b1;
    op_a = 16'hA5A5;
    op_b = 16'h1111;
    sub  = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    wait_result(16'hA5A5, 16'h1111, 1'b0, "bp1");
    exp = model(16'hA5A5, 16'h1111, 1'b0);
    start_valid = 1'b1;
    op_a = 16'h4000;
    op_b = 16'h0123;
    sub  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp valid", res_valid, 1);
      chk("bp result", result, exp[W-1:0]);
      chk("bp carry", carry_out, exp[W]);
      chk("bp ovf", overflow, exp[W+1]);
      chk("bp start_ready", start_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("bp idle valid", res_valid, 0);
    chk("bp idle ready", start_ready, 1);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    chk("bp accepted", busy, 1);
    wait_result(16'h4000, 16'h0123, 1'b1, "bp2");
    exp = model(16'h4000, 16'h0123, 1'b1);
    release_result(exp[W-1:0], "bp2");

    // Reset during the second RUN cycle.
    start_valid = 1'b1;
    op_a = 16'h3333;
    op_b = 16'h4444;
    sub  = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort result", result, 0);
    chk("abort valid", res_valid, 0);
    chk("abort ready", start_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort carry", carry_out, 0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort no pulse", res_valid, 0);
    end
    do_op(16'h00FF, 16'h0001, 1'b0, "post");

    for (int i = 0; i < 40; i++) begin
      ha = W'($urandom);
      do_op(ha, W'($urandom), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
